rx_decimator: RTL and testbench
===============================

# rx_decimator

Downstream stage of the RX low-pass filter. It captures each filtered sample on a one-cycle strobe and decimates the stream by a power-of-two factor. Decimated samples are buffered in a small synchronous FIFO and presented to the next RX stage through a valid/ready handshake. Decimation is either plain sample-picking or, if configured, a boxcar average.

## Interface
Parameters:
- DECIM, 4, decimation factor; power of two, 2..128
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥2

Ports:
- crx_clk  in  1  clock
- rrx_rst_n  in  1  reset, asynchronous, active-low
- erx_en  in  1  enable; low clears the block synchronously
- idata_in  in  16 signed  filtered sample from the low-pass filter
- idata_valid  in  1  one-cycle strobe; idata_in is valid this cycle
- odata_out  out  16 signed  head of FIFO
- odata_valid  out  1  FIFO non-empty
- idata_ready  in  1  consumer accepts odata_out this cycle
- ooverflow  out  1  sticky; a decimated sample was dropped
- ofifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Phase counter pcnt runs 0..DECIM-1 and advances by one on each idata_valid while erx_en=1. It wraps from DECIM-1 to 0.
- Pick mode: when idata_valid=1 and pcnt=DECIM-1, push idata_in.
- Average mode: accumulator acc is 16+log2(DECIM) bits signed.
  - pcnt=0 loads acc with idata_in.
  - Other phases add idata_in to acc.
  - At pcnt=DECIM-1, push (acc+idata_in) >>> log2(DECIM). This is an arithmetic shift, truncating toward −∞.
- Pop happens when odata_valid=1 and idata_ready=1. odata_out is first-word-fall-through.
- FIFO full with a push and no pop: the sample is dropped, ooverflow is set, and pcnt/acc still advance normally.
- FIFO full with a push and a pop in the same cycle: both are accepted and the level is unchanged.
- FIFO empty with a push: there is no combinational bypass. odata_valid rises the next cycle.
- idata_ready while odata_valid=0: ignored.
- erx_en=0 synchronously clears pcnt, acc, FIFO pointers, level and ooverflow. Strobes are ignored while disabled.
- ooverflow clears only on reset or erx_en=0.

## Timing
- Reset values: odata_out=0, odata_valid=0, ooverflow=0, ofifo_level=0, pcnt=0, acc=0.
- Reset assertion is asynchronous and mid-operation; it discards FIFO contents immediately.
- Latency: the push strobe at cycle N is written at edge N+1. odata_valid and the new ofifo_level are visible from cycle N+1.
- Throughput: one push per strobe, at most one pop per cycle. Strobes may arrive on consecutive cycles; the block handles this at full rate.
- ooverflow asserts in the cycle after the dropped push.
- erx_en deasserted at cycle N: all state is cleared from cycle N+1.

## Configuration
- Macro: RX_DECIM_AVG_EN.
- Defined: average mode; the accumulator is built.
- Undefined: pick mode; no accumulator or adder is instantiated. Every other behaviour is identical.

## Structure
- Shared package rx_pkg holds:
  - RX_SAMPLE_W=16
  - a function for the log2 of DECIM
  - the FIFO level width computation
- One sub-module: rx_sync_fifo.
  - Parameterised width/depth, single clock, first-word-fall-through.
  - Has push/pop/full/empty/level and a synchronous clear, driven from erx_en.
  - The decimator itself contains only the phase counter, the accumulator and the overflow logic.

## Test plan
- Pick, DECIM=4: strobe samples 1..16 with idata_ready=1. Required output is 4, 8, 12, 16, each with odata_valid one cycle after the 4th strobe of its group.
- Average, DECIM=4: inputs −3, −2, −1, 1 give output −2 (sum −5 >>> 2). Inputs 32767×4 give 32767 with no wrap.
- Overflow, FIFO_DEPTH=16, idata_ready=0: push 17 decimated samples. ofifo_level=16 and ooverflow=1 from the cycle after push 17. Draining yields the first 16 values in order.
- Full with simultaneous push and pop: the level stays at 16, ooverflow stays 0, and the new sample appears at the tail.
- Mid-stream control: assert rrx_rst_n=0 asynchronously mid-group. All outputs go to 0 immediately, and after release the next group starts at pcnt=0.
- Mid-stream enable drop: the same check with erx_en=0 for one cycle, which clears on the next edge.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared RX definitions: sample width, log2 helper, FIFO level width.
package rx_pkg;

    localparam int RX_SAMPLE_W = 16;

    // Ceil-log2 for elaboration-time sizing (exact for powers of two).
    function automatic int rx_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // A level counter must represent 0..depth inclusive.
    function automatic int rx_level_w(input int depth);
        return rx_log2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module rx_sync_fifo
    import rx_pkg::*;
#(
    parameter int WIDTH = RX_SAMPLE_W,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [rx_level_w(DEPTH)-1:0]  level
);

    localparam int AW = rx_log2(DEPTH);
    localparam int LW = rx_level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Storage is not reset, so the head is masked to zero while empty.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Sample storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/rx_decimator.sv
// RX decimator: captures strobed filtered samples, decimates by DECIM and
// queues results in an output FIFO with a valid/ready handshake.
// Define RX_DECIM_AVG_EN for boxcar averaging; otherwise the last sample of
// each group is picked and no accumulator exists.
module rx_decimator
    import rx_pkg::*;
#(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                crx_clk,
    input  logic                                rrx_rst_n,
    input  logic                                erx_en,
    input  logic signed [RX_SAMPLE_W-1:0]       idata_in,
    input  logic                                idata_valid,
    output logic signed [RX_SAMPLE_W-1:0]       odata_out,
    output logic                                odata_valid,
    input  logic                                idata_ready,
    output logic                                ooverflow,
    output logic [rx_level_w(FIFO_DEPTH)-1:0]   ofifo_level
);

    localparam int            PW   = rx_log2(DECIM);
    localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

    logic [PW-1:0]                 pcnt;
    logic                          push;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_clr;
    logic signed [RX_SAMPLE_W-1:0] push_data;

    assign push     = erx_en & idata_valid & (pcnt == LAST);
    assign fifo_clr = ~erx_en;

    // Phase counter; power-of-two DECIM lets it wrap naturally.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n)       pcnt <= '0;
        else if (!erx_en)     pcnt <= '0;
        else if (idata_valid) pcnt <= pcnt + PW'(1);
    end

`ifdef RX_DECIM_AVG_EN
    localparam int AW = RX_SAMPLE_W + PW;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] sum;

    // Accumulator is wide enough that DECIM full-scale samples cannot wrap.
    assign ext       = {{PW{idata_in[RX_SAMPLE_W-1]}}, idata_in};
    assign sum       = acc + ext;
    assign push_data = RX_SAMPLE_W'(sum >>> PW);

    // Boxcar accumulator: phase 0 reloads, later phases accumulate.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n)       acc <= '0;
        else if (!erx_en)     acc <= '0;
        else if (idata_valid) acc <= (pcnt == '0) ? ext : sum;
    end
`else
    assign push_data = idata_in;
`endif

    // Sticky drop flag: full FIFO, push requested, no pop to make room.
    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n)                             ooverflow <= 1'b0;
        else if (!erx_en)                           ooverflow <= 1'b0;
        else if (push && fifo_full && !idata_ready) ooverflow <= 1'b1;
    end

    rx_sync_fifo #(
        .WIDTH (RX_SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (crx_clk),
        .rst_n (rrx_rst_n),
        .clr   (fifo_clr),
        .push  (push),
        .wdata (push_data),
        .pop   (idata_ready),
        .rdata (odata_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (ofifo_level)
    );

    assign odata_valid = ~fifo_empty;

endmodule

// File: tb/tb_rx_decimator.sv
// Directed bench for rx_decimator (DECIM=4, FIFO_DEPTH=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_rx_decimator;

    logic               crx_clk;
    logic               rrx_rst_n;
    logic               erx_en;
    logic signed [15:0] idata_in;
    logic               idata_valid;
    logic signed [15:0] odata_out;
    logic               odata_valid;
    logic               idata_ready;
    logic               ooverflow;
    logic [4:0]         ofifo_level;

    int n_chk = 0;
    int n_err = 0;
    int q[$];

    rx_decimator #(.DECIM(4), .FIFO_DEPTH(16)) dut (
        .crx_clk     (crx_clk),
        .rrx_rst_n   (rrx_rst_n),
        .erx_en      (erx_en),
        .idata_in    (idata_in),
        .idata_valid (idata_valid),
        .odata_out   (odata_out),
        .odata_valid (odata_valid),
        .idata_ready (idata_ready),
        .ooverflow   (ooverflow),
        .ofifo_level (ofifo_level)
    );

    initial crx_clk = 1'b0;
    always #5 crx_clk = ~crx_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected decimated value of one group of four samples.
    function automatic int model(input int a, input int b, input int c, input int d);
`ifdef RX_DECIM_AVG_EN
        return (a + b + c + d) >>> 2;
`else
        return d;
`endif
    endfunction

    // One strobe; returns at the falling edge after the capturing edge.
    task automatic send(input int v);
        idata_in    = 16'(v);
        idata_valid = 1'b1;
        @(posedge crx_clk);
        @(negedge crx_clk);
        idata_valid = 1'b0;
    endtask

    task automatic send_group(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge crx_clk);
            @(negedge crx_clk);
        end
    endtask

    // Pop everything in q, checking order, then confirm empty.
    task automatic drain(input string tag);
        int e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_data"}, int'(odata_out), e);
            idata_ready = 1'b1;
            @(posedge crx_clk);
            @(negedge crx_clk);
            idata_ready = 1'b0;
        end
        chk({tag, "_empty"}, int'(odata_valid), 0);
    endtask

    initial begin
        int v;
        rrx_rst_n   = 1'b0;
        erx_en      = 1'b0;
        idata_in    = '0;
        idata_valid = 1'b0;
        idata_ready = 1'b0;
        idle(2);
        chk("rst_data",  int'(odata_out),   0);
        chk("rst_valid", int'(odata_valid), 0);
        chk("rst_ovf",   int'(ooverflow),   0);
        chk("rst_level", int'(ofifo_level), 0);
        rrx_rst_n = 1'b1;
        erx_en    = 1'b1;
        idle(1);

        // Samples 1..16 back to back, consumer always ready.
        idata_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send(4*k - 3);
            chk("pick_gap", int'(odata_valid), 0);
            send(4*k - 2);
            send(4*k - 1);
            chk("pick_pre", int'(odata_valid), 0);
            send(4*k);
            chk("pick_valid", int'(odata_valid), 1);
            chk("pick_data", int'(odata_out), model(4*k-3, 4*k-2, 4*k-1, 4*k));
        end
        idle(1);
        chk("pick_popped", int'(odata_valid), 0);
        idata_ready = 1'b0;

        // Rounding toward -inf and full-scale input.
        send_group(-3, -2, -1, 1);
        chk("avg_neg", int'(odata_out), model(-3, -2, -1, 1));
        send_group(32767, 32767, 32767, 32767);
        chk("avg_lvl", int'(ofifo_level), 2);
        q.push_back(model(-3, -2, -1, 1));
        q.push_back(32767);
        drain("avg");

        // Overflow: 17 pushes into a 16-deep FIFO with no consumer.
        for (int k = 1; k <= 17; k++) begin
            v = 100 + k;
            send_group(v, v, v, v);
            if (k <= 16) q.push_back(v);
            if (k == 16) begin
                chk("ovf_lvl16", int'(ofifo_level), 16);
                chk("ovf_pre",   int'(ooverflow),   0);
            end
        end
        chk("ovf_lvl17", int'(ofifo_level), 16);
        chk("ovf_set",   int'(ooverflow),   1);
        drain("ovf");
        chk("ovf_sticky", int'(ooverflow), 1);
        erx_en = 1'b0;
        idle(1);
        chk("ovf_clr", int'(ooverflow), 0);
        erx_en = 1'b1;

        // Full FIFO with push and pop in the same cycle.
        for (int k = 1; k <= 16; k++) begin
            v = 200 + k;
            send_group(v, v, v, v);
            q.push_back(v);
        end
        send(217); send(217); send(217);
        idata_ready = 1'b1;
        send(217);
        idata_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(217);
        chk("pp_level", int'(ofifo_level), 16);
        chk("pp_ovf",   int'(ooverflow),   0);
        chk("pp_head",  int'(odata_out),   202);
        drain("pp");

        // Asynchronous reset mid-group.
        send_group(301, 301, 301, 301);
        send(5); send(6);
        chk("ar_pre", int'(ofifo_level), 1);
        #2 rrx_rst_n = 1'b0;
        #1;
        chk("ar_data",  int'(odata_out),   0);
        chk("ar_valid", int'(odata_valid), 0);
        chk("ar_level", int'(ofifo_level), 0);
        @(negedge crx_clk);
        rrx_rst_n = 1'b1;
        send(302); send(302); send(302);
        chk("ar_phase3", int'(odata_valid), 0);
        send(302);
        chk("ar_phase4", int'(odata_out), 302);
        q.push_back(302);
        drain("ar");

        // Enable low for one cycle mid-group, with a strobe that must be ignored.
        send_group(401, 401, 401, 401);
        send(7); send(8);
        erx_en = 1'b0;
        send(9);
        erx_en = 1'b1;
        chk("en_level", int'(ofifo_level), 0);
        chk("en_valid", int'(odata_valid), 0);
        send(402); send(402); send(402);
        chk("en_phase3", int'(ofifo_level), 0);
        send(402);
        chk("en_phase4", int'(ofifo_level), 1);
        q.push_back(402);
        drain("en");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
